atmega_tim_prescaler: RTL and testbench

Shared clock-prescaler and external-clock sampling stage that sits directly upstream of the 8-bit and 16-bit timer blocks. It owns the GTCCR register and produces the clk8/clk64/clk256/clk1024 divided-clock levels. It also produces single-cycle synchronized edge strobes from the external Tn pins, which the timers select as their count source through CSn2:0 = 110/111. Timers detect rising edges of whichever source is selected, so every output here is a level or strobe in the clk domain.

---
 rtl/atmega_tim_prescaler_pkg.sv | 43 ++++
 rtl/atmega_tim_prescaler_if.sv | 15 +
 rtl/atmega_tim_prescaler_tim_pin_sync.sv | 32 +++
 rtl/atmega_tim_prescaler.sv | 80 ++++++++
 tb/tb_atmega_tim_prescaler.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/atmega_tim_prescaler_pkg.sv
// Shared timer constants: GTCCR bit positions, default IO address and prescaler tap points.
// The 8-bit and 16-bit timer blocks import the same package.
package atmega_tim_prescaler_pkg;

  localparam int BUS_ADDR_IO_LEN_DFLT = 6;
  localparam int GTCCR_ADDR_DFLT      = 'h23;

  localparam int GTCCR_TSM     = 7;
  localparam int GTCCR_PSRASY  = 1;
  localparam int GTCCR_PSRSYNC = 0;

  localparam int PCNT_W      = 10;
  localparam int CLK8_BIT    = 2;
  localparam int CLK64_BIT   = 5;
  localparam int CLK256_BIT  = 7;
  localparam int CLK1024_BIT = 9;

  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic tsm;
    logic psrasy;
    logic psrsync;
  } gtccr_t;

  function automatic logic [7:0] gtccr_pack(gtccr_t g);
    logic [7:0] v;
    v                = 8'h00;
    v[GTCCR_TSM]     = g.tsm;
    v[GTCCR_PSRASY]  = g.psrasy;
    v[GTCCR_PSRSYNC] = g.psrsync;
    return v;
  endfunction

  function automatic gtccr_t gtccr_unpack(logic [7:0] v);
    gtccr_t g;
    g.tsm     = v[GTCCR_TSM];
    g.psrasy  = v[GTCCR_PSRASY];
    g.psrsync = v[GTCCR_PSRSYNC];
    return g;
  endfunction

endpackage

// File: rtl/atmega_tim_prescaler_if.sv
// IO-bus bundle between the CPU IO space and the prescaler register.
interface atmega_tim_prescaler_if
  import atmega_tim_prescaler_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_IO_LEN_DFLT
);
  logic [ADDR_W-1:0] addr_io;
  logic              wr_io;
  logic              rd_io;
  logic [7:0]        bus_io_in;
  logic [7:0]        bus_io_out;

  modport master (output addr_io, wr_io, rd_io, bus_io_in, input bus_io_out);
  modport slave  (input addr_io, wr_io, rd_io, bus_io_in, output bus_io_out);
endinterface

// File: rtl/atmega_tim_prescaler_tim_pin_sync.sv
// One external count pin: two-flop synchronizer, history flop and registered edge strobes.
module tim_pin_sync
  import atmega_tim_prescaler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_t,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_t};
      r_hist <= w_sync;
      o_rise <= w_sync & ~r_hist;
      o_fall <= ~w_sync & r_hist;
    end
  end

endmodule

// File: rtl/atmega_tim_prescaler.sv
// Shared timer prescaler: GTCCR register, free-running 10-bit divider with clkN taps,
// and synchronized edge strobes for the external Tn count pins.
module atmega_tim_prescaler
  import atmega_tim_prescaler_pkg::*;
#(
  parameter int                         BUS_ADDR_IO_LEN = BUS_ADDR_IO_LEN_DFLT,
  parameter logic [BUS_ADDR_IO_LEN-1:0] GTCCR_ADDR      = BUS_ADDR_IO_LEN'(GTCCR_ADDR_DFLT),
  parameter int                         T_CNT           = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  atmega_tim_prescaler_if.slave bus,
  output logic                 o_clk8,
  output logic                 o_clk64,
  output logic                 o_clk256,
  output logic                 o_clk1024,
  input  logic [T_CNT-1:0]     i_t,
  output logic [T_CNT-1:0]     o_t_rise,
  output logic [T_CNT-1:0]     o_t_fall,
  output logic                 o_psrasy_pulse
);

  logic [PCNT_W-1:0] r_pcnt;
  gtccr_t            r_gtccr;
  gtccr_t            w_wdata;
  logic              w_wr_gtccr;
  logic              w_rd_gtccr;
  logic              w_unused;

  assign w_wr_gtccr = bus.wr_io && (bus.addr_io == GTCCR_ADDR);
  assign w_rd_gtccr = bus.rd_io && (bus.addr_io == GTCCR_ADDR);
  assign w_wdata    = gtccr_unpack(bus.bus_io_in);
  assign w_unused   = &{1'b0, bus.bus_io_in[6:2]};

  // PSR bits self-clear one edge after being set unless TSM holds them; a write that
  // keeps TSM set cannot drop a PSR bit that is already being held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gtccr <= '0;
    end else if (w_wr_gtccr) begin
      r_gtccr.tsm     <= w_wdata.tsm;
      r_gtccr.psrasy  <= w_wdata.psrasy  | (r_gtccr.psrasy  & w_wdata.tsm);
      r_gtccr.psrsync <= w_wdata.psrsync | (r_gtccr.psrsync & w_wdata.tsm);
    end else if (!r_gtccr.tsm) begin
      r_gtccr.psrasy  <= 1'b0;
      r_gtccr.psrsync <= 1'b0;
    end
  end

  // A PSRSYNC write takes priority over the natural wrap; the counter then sits at 0
  // for as long as the bit stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if ((w_wr_gtccr && w_wdata.psrsync) || r_gtccr.psrsync) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PCNT_W'(1);
    end
  end

  assign o_clk8         = r_pcnt[CLK8_BIT];
  assign o_clk64        = r_pcnt[CLK64_BIT];
  assign o_clk256       = r_pcnt[CLK256_BIT];
  assign o_clk1024      = r_pcnt[CLK1024_BIT];
  assign o_psrasy_pulse = r_gtccr.psrasy;

  assign bus.bus_io_out = w_rd_gtccr ? gtccr_pack(r_gtccr) : 8'h00;

  for (genvar gi = 0; gi < T_CNT; gi++) begin : g_pin
    tim_pin_sync u_pin_sync (
      .clk    (clk),
      .rst    (rst),
      .i_t    (i_t[gi]),
      .o_rise (o_t_rise[gi]),
      .o_fall (o_t_fall[gi])
    );
  end

endmodule

// File: tb/tb_atmega_tim_prescaler.sv
// Directed bench for atmega_tim_prescaler: divider-edge and pin-strobe scoreboard plus GTCCR checks.
module tb_atmega_tim_prescaler;

  localparam int T_CNT = 2;

  typedef struct {
    int ch;
    int cyc;
  } ev_t;

  logic             clk;
  logic             rst;
  logic             o_clk8, o_clk64, o_clk256, o_clk1024;
  logic [T_CNT-1:0] i_t;
  logic [T_CNT-1:0] o_t_rise, o_t_fall;
  logic             o_psrasy_pulse;

  atmega_tim_prescaler_if #(.ADDR_W(6)) bif ();

  atmega_tim_prescaler #(
    .BUS_ADDR_IO_LEN (6),
    .GTCCR_ADDR      (6'h23),
    .T_CNT           (T_CNT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bif),
    .o_clk8         (o_clk8),
    .o_clk64        (o_clk64),
    .o_clk256       (o_clk256),
    .o_clk1024      (o_clk1024),
    .i_t            (i_t),
    .o_t_rise       (o_t_rise),
    .o_t_fall       (o_t_fall),
    .o_psrasy_pulse (o_psrasy_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc   = 0;
  bit         mon_on  = 0;
  bit         duty_on = 0;
  logic [3:0] prev_lv = 4'b0000;
  int         hi [4];
  ev_t        sbq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      $error("check %s", tag);
    end
  endtask

  function automatic string ch_name(input int ch);
    case (ch)
      0: return "clk8_rise";
      1: return "clk64_rise";
      2: return "clk256_rise";
      3: return "clk1024_rise";
      4: return "t_rise0";
      5: return "t_fall0";
      6: return "t_rise1";
      7: return "t_fall1";
      default: return "psrasy_pulse";
    endcase
  endfunction

  function automatic logic [3:0] lv();
    return {o_clk1024, o_clk256, o_clk64, o_clk8};
  endfunction

  task automatic sb_push(input int ch, input int c);
    ev_t e;
    e.ch  = ch;
    e.cyc = c;
    sbq.push_back(e);
  endtask

  // Pops the oldest expectation on this channel; an event with none pending is a failure.
  task automatic sb_pop(input int ch);
    int idx;
    idx = -1;
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].ch == ch) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      chk({ch_name(ch), "_unexpected"}, cyc, 32'hFFFF_FFFF);
    end else begin
      chk(ch_name(ch), cyc, sbq[idx].cyc);
      sbq.delete(idx);
    end
  endtask

  // Counter is 0 at cycle c0 and counts freely for n cycles: clkN rises at each pcnt = N/2 mod N.
  task automatic push_run(input int c0, input int n);
    for (int p = 1; p <= n; p++) begin
      if (p % 8 == 4)      sb_push(0, c0 + p);
      if (p % 64 == 32)    sb_push(1, c0 + p);
      if (p % 256 == 128)  sb_push(2, c0 + p);
      if (p % 1024 == 512) sb_push(3, c0 + p);
    end
  endtask

  task automatic step();
    logic [3:0] cur;
    @(posedge clk);
    #1;
    cyc++;
    cur = lv();
    if (mon_on) begin
      for (int c = 0; c < 4; c++) if (cur[c] && !prev_lv[c]) sb_pop(c);
      if (o_t_rise[0])    sb_pop(4);
      if (o_t_fall[0])    sb_pop(5);
      if (o_t_rise[1])    sb_pop(6);
      if (o_t_fall[1])    sb_pop(7);
      if (o_psrasy_pulse) sb_pop(8);
    end
    if (duty_on && cyc >= 1 && cyc <= 2048)
      for (int c = 0; c < 4; c++) hi[c] += int'(cur[c]);
    prev_lv = cur;
  endtask

  task automatic rd_reg(input logic [5:0] a, input logic rd, output logic [7:0] v);
    bif.addr_io = a;
    bif.rd_io   = rd;
    #1;
    v = bif.bus_io_out;
    bif.rd_io = 1'b0;
  endtask

  task automatic wr_gtccr(input logic [7:0] d);
    bif.addr_io   = 6'h23;
    bif.bus_io_in = d;
    bif.wr_io     = 1'b1;
    step();
    bif.wr_io     = 1'b0;
    bif.bus_io_in = 8'h00;
  endtask

  initial begin
    logic [7:0] v;
    int w, r;
    rst = 1'b1;
    i_t = '0;
    bif.addr_io = '0; bif.wr_io = 1'b0; bif.rd_io = 1'b0; bif.bus_io_in = 8'h00;
    for (int c = 0; c < 4; c++) hi[c] = 0;

    repeat (3) step();
    chk("rst_clkN", {28'h0, lv()}, 32'h0);
    chk("rst_strobes", {27'h0, o_t_fall, o_t_rise, o_psrasy_pulse}, 32'h0);
    rd_reg(6'h23, 1'b1, v);
    chk("rst_gtccr", {24'h0, v}, 32'h0);

    // Free run from reset release: cycle n ends with pcnt = n.
    rst = 1'b0; cyc = 0; mon_on = 1; duty_on = 1;
    push_run(0, 2348);
    repeat (2348) step();
    duty_on = 0;
    chk("duty_clk8",    hi[0], 1024);
    chk("duty_clk64",   hi[1], 1024);
    chk("duty_clk256",  hi[2], 1024);
    chk("duty_clk1024", hi[3], 1024);
    chk("pcnt300_levels", {28'h0, lv()}, 32'h3);

    // PSRSYNC with TSM=0: zero on the write edge, held one cycle, then counting.
    wr_gtccr(8'h01);
    w = cyc;
    chk("sync_levels0", {28'h0, lv()}, 32'h0);
    rd_reg(6'h23, 1'b1, v);
    chk("sync_read_set", {24'h0, v}, 32'h01);
    step();
    rd_reg(6'h23, 1'b1, v);
    chk("sync_read_clr", {24'h0, v}, 32'h00);
    chk("sync_levels1", {28'h0, lv()}, 32'h0);
    push_run(w + 1, 40);
    while (cyc < w + 41) step();

    // TSM hold, then release by writing 0.
    wr_gtccr(8'h81);
    chk("tsm_levels0", {28'h0, lv()}, 32'h0);
    repeat (100) begin
      step();
      chk("tsm_hold_levels", {28'h0, lv()}, 32'h0);
    end
    rd_reg(6'h23, 1'b1, v);
    chk("tsm_read", {24'h0, v}, 32'h81);
    rd_reg(6'h23, 1'b0, v);
    chk("rd_disabled", {24'h0, v}, 32'h00);
    rd_reg(6'h22, 1'b1, v);
    chk("rd_other_addr", {24'h0, v}, 32'h00);
    wr_gtccr(8'h00);
    r = cyc;
    rd_reg(6'h23, 1'b1, v);
    chk("tsm_release_read", {24'h0, v}, 32'h00);
    push_run(r, 200);
    repeat (20) step();

    // PSRASY pulse while the divider keeps running.
    sb_push(8, cyc + 1);
    wr_gtccr(8'h02);
    rd_reg(6'h23, 1'b1, v);
    chk("psrasy_read_set", {24'h0, v}, 32'h02);
    step();
    rd_reg(6'h23, 1'b1, v);
    chk("psrasy_read_clr", {24'h0, v}, 32'h00);

    // t[0] high for 5 sampling edges; t[1] stays quiet.
    sb_push(4, cyc + 3);
    sb_push(5, cyc + 8);
    i_t[0] = 1'b1;
    repeat (5) step();
    i_t[0] = 1'b0;
    while (cyc < r + 200) step();
    chk("sb_drained_run", sbq.size(), 0);

    // Pins held high through a mid-run reset strobe 3 edges after release.
    rst = 1'b1; mon_on = 0;
    i_t = '1;
    repeat (3) step();
    chk("rst2_clkN", {28'h0, lv()}, 32'h0);
    chk("rst2_strobes", {27'h0, o_t_fall, o_t_rise, o_psrasy_pulse}, 32'h0);
    rst = 1'b0; cyc = 0; mon_on = 1;
    sb_push(4, 3);
    sb_push(6, 3);
    push_run(0, 12);
    repeat (12) step();
    chk("sb_drained_rst", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
